// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file, 2 async reads, 1 sync write, sequenced bulk clear
module regfile_param #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter bit ZERO_REG  = 1'b1,
    parameter bit BYPASS    = 1'b1
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [ADDR_BITS-1:0] ReadRegister1,
    input  logic [ADDR_BITS-1:0] ReadRegister2,
    output logic [WIDTH-1:0]     ReadData1,
    output logic [WIDTH-1:0]     ReadData2,
    input  logic [ADDR_BITS-1:0] WriteRegister,
    input  logic [WIDTH-1:0]     WriteData,
    input  logic                 RegWrite,
    input  logic                 ClearReq,
    output logic                 ClearBusy,
    output logic                 ClearDone
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t               state, state_next;
    logic [ADDR_BITS-1:0] ptr, ptr_next;
    logic                 busy_next, done_next;
    logic [WIDTH-1:0]     regs [DEPTH];
    logic                 wr_zero, wr_en, bypass_ok;

    assign wr_zero   = ZERO_REG && (WriteRegister == '0);
    // The file is already clear in DONE, so a write there is safe to honour.
    assign wr_en     = RegWrite && !wr_zero && (state == IDLE || state == DONE);
    assign bypass_ok = BYPASS && RegWrite && !wr_zero && (state == IDLE);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            ClearBusy <= 1'b0;
            ClearDone <= 1'b0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            ClearBusy <= busy_next;
            ClearDone <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (ClearReq) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                    busy_next  = 1'b1;
                end
            end
            CLEAR: begin
                // ptr wraps back to 0 on the final increment.
                ptr_next = ptr + 1'b1;
                if (ptr == LAST) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    busy_next = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (state == CLEAR) begin
            regs[ptr] <= '0;
        end else if (wr_en) begin
            regs[WriteRegister] <= WriteData;
        end
    end

    always_comb begin
        ReadData1 = regs[ReadRegister1];
        if (bypass_ok && (WriteRegister == ReadRegister1)) ReadData1 = WriteData;
        if (ZERO_REG && (ReadRegister1 == '0)) ReadData1 = '0;
    end

    always_comb begin
        ReadData2 = regs[ReadRegister2];
        if (bypass_ok && (WriteRegister == ReadRegister2)) ReadData2 = WriteData;
        if (ZERO_REG && (ReadRegister2 == '0)) ReadData2 = '0;
    end
endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - self-checking bench for regfile_param (default, ZERO_REG=0, BYPASS=0)
module tb_regfile_param;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr;
    logic [31:0] wr_data;
    logic        reg_write, clear_req;

    logic [31:0] rd1_a, rd2_a, rd1_z, rd2_z, rd1_b, rd2_b;
    logic        busy_a, done_a, busy_z, done_z, busy_b, done_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_param dut_a (
        .Clk(clk), .Rst_n(rst_n), .ReadRegister1(rd_addr1), .ReadRegister2(rd_addr2),
        .ReadData1(rd1_a), .ReadData2(rd2_a), .WriteRegister(wr_addr), .WriteData(wr_data),
        .RegWrite(reg_write), .ClearReq(clear_req), .ClearBusy(busy_a), .ClearDone(done_a)
    );

    regfile_param #(.ZERO_REG(1'b0)) dut_z (
        .Clk(clk), .Rst_n(rst_n), .ReadRegister1(rd_addr1), .ReadRegister2(rd_addr2),
        .ReadData1(rd1_z), .ReadData2(rd2_z), .WriteRegister(wr_addr), .WriteData(wr_data),
        .RegWrite(reg_write), .ClearReq(clear_req), .ClearBusy(busy_z), .ClearDone(done_z)
    );

    regfile_param #(.BYPASS(1'b0)) dut_b (
        .Clk(clk), .Rst_n(rst_n), .ReadRegister1(rd_addr1), .ReadRegister2(rd_addr2),
        .ReadData1(rd1_b), .ReadData2(rd2_b), .WriteRegister(wr_addr), .WriteData(wr_data),
        .RegWrite(reg_write), .ClearReq(clear_req), .ClearBusy(busy_b), .ClearDone(done_b)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_a;
        logic [31:0] exp_z;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] exp_a;
        logic [31:0] exp_z;
    } sb_t;

    vec_t vecs [5];
    sb_t  sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        wr_addr   = a;
        wr_data   = d;
        reg_write = 1'b1;
        step();
        reg_write = 1'b0;
    endtask

    initial begin
        int busy_cnt, done_cnt;
        sb_t e;

        vecs[0] = '{5'd15, 32'h0000001B, 32'h0000001B, 32'h0000001B};
        vecs[1] = '{5'd0,  32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
        vecs[2] = '{5'd7,  32'h00000011, 32'h00000011, 32'h00000011};
        vecs[3] = '{5'd31, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[4] = '{5'd1,  32'h12345678, 32'h12345678, 32'h12345678};

        rst_n = 1'b0; rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0;
        wr_data = '0; reg_write = 1'b0; clear_req = 1'b0;
        step(); step();
        check("reset_busy", {31'd0, busy_a}, 32'd0);
        check("reset_done", {31'd0, done_a}, 32'd0);
        rd_addr1 = 5'd15; rd_addr2 = 5'd31; #1;
        check("reset_rd1", rd1_z, 32'd0);
        check("reset_rd2", rd2_a, 32'd0);
        rst_n = 1'b1;
        step();

        // table-driven writes with pre-edge bypass check, results queued for readback
        foreach (vecs[i]) begin
            wr_addr = vecs[i].addr; wr_data = vecs[i].data; reg_write = 1'b1;
            rd_addr1 = vecs[i].addr; #1;
            check($sformatf("bypass_pre_a[%0d]", i), rd1_a, vecs[i].exp_a);
            check($sformatf("bypass_pre_z[%0d]", i), rd1_z, vecs[i].exp_z);
            sb_q.push_back('{vecs[i].addr, vecs[i].exp_a, vecs[i].exp_z});
            step();
            reg_write = 1'b0;
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rd_addr1 = e.addr; rd_addr2 = e.addr; #1;
            check($sformatf("read1_a[%0d]", e.addr), rd1_a, e.exp_a);
            check($sformatf("read2_a[%0d]", e.addr), rd2_a, e.exp_a);
            check($sformatf("read1_z[%0d]", e.addr), rd1_z, e.exp_z);
            check($sformatf("read1_b[%0d]", e.addr), rd1_b, e.exp_a);
        end

        // bypass vs no-bypass on reg 7 (holds 0x11)
        wr_addr = 5'd7; wr_data = 32'h22; reg_write = 1'b1; rd_addr1 = 5'd7; #1;
        check("bypass_on_pre", rd1_a, 32'h22);
        check("bypass_off_pre", rd1_b, 32'h11);
        step();
        reg_write = 1'b0; #1;
        check("bypass_off_post", rd1_b, 32'h22);

        // fill and clear
        for (int i = 0; i < 32; i++) write_reg(5'(i), 32'hA5A5A5A5);
        rd_addr1 = 5'd31; rd_addr2 = 5'd31; #1;
        check("fill_r31", rd1_z, 32'hA5A5A5A5);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_a) busy_cnt++;
            if (done_a) done_cnt++;
            if (i == 5) begin
                wr_addr = 5'd31; wr_data = 32'h5; reg_write = 1'b1; clear_req = 1'b1;
                rd_addr1 = 5'd31; #1;
                check("clear_no_bypass", rd1_a, 32'hA5A5A5A5);
                check("clear_old_value", rd2_z, 32'hA5A5A5A5);
            end else begin
                reg_write = 1'b0; clear_req = 1'b0;
            end
            step();
        end
        reg_write = 1'b0; clear_req = 1'b0;
        check("clear_busy_cycles", busy_cnt, 32);
        check("clear_done_pulses", done_cnt, 1);
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i); #1;
            check($sformatf("cleared_a[%0d]", i), rd1_a, 32'd0);
            check($sformatf("cleared_z[%0d]", i), rd1_z, 32'd0);
        end

        // reset asserted mid-clear at ptr=10
        write_reg(5'd20, 32'h99);
        write_reg(5'd3, 32'h77);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rd_addr1 = 5'd20; rd_addr2 = 5'd20; #1;
        check("midclear_r20", rd1_z, 32'h99);
        rst_n = 1'b0; #1;
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_r20", rd1_z, 32'd0);
        check("rst_r20_p2", rd2_a, 32'd0);
        step();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_a || busy_a) done_cnt++;
            step();
        end
        check("no_done_after_reset", done_cnt, 0);
        write_reg(5'd9, 32'hCAFE);
        rd_addr1 = 5'd9; #1;
        check("post_reset_write", rd1_a, 32'hCAFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
